// File: rtl/image_cell_builder.sv
// Raster pixel stream to 3x3 cell window builder: two line buffers plus a two-column
// shift window, one registered output cell per valid window centre.
package CellProcessingPkg;
  localparam int cellN = 3;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } pixel_t;

  typedef struct packed {
    pixel_t [0:cellN-1][0:cellN-1] pixelMatrix;
  } cell_t;
endpackage

module image_cell_builder
  import CellProcessingPkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  localparam int XW = $clog2(IMG_W),
  localparam int YW = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  pixel_t        pix_in,
  input  logic          pix_sof,
  input  logic          pix_valid,
  output logic          pix_ready,
  output cell_t         cell_out,
  output logic [XW-1:0] cell_x,
  output logic [YW-1:0] cell_y,
  output logic          cell_last,
  output logic          cell_valid,
  input  logic          cell_ready,
  output logic          sof_err
);

  localparam logic [1:0] WAIT_SOF = 2'd0;
  localparam logic [1:0] ACTIVE   = 2'd1;
  localparam logic [1:0] DONE     = 2'd2;

  logic [1:0]    state;
  logic [XW-1:0] x, px;
  logic [YW-1:0] y, py;
  logic          accept, emit, restart, process, complete;

  pixel_t lb1 [IMG_W];
  pixel_t lb2 [IMG_W];
  // win[r][c]: row r of the window (0 = line y-2), columns x-2 and x-1
  pixel_t win [cellN][cellN-1];
  pixel_t new_col [cellN];

  assign pix_ready = (state != DONE) && (!cell_valid || cell_ready);
  assign accept    = pix_valid && pix_ready;
  assign emit      = cell_valid && cell_ready;
  assign restart   = accept && pix_sof;
  assign process   = accept && (pix_sof || (state == ACTIVE));

  // NOTE: combinational blocks use blocking '=' and give every output a value first, so no latch is inferred.
  always_comb begin
    px = x;
    py = y;
    if (restart) begin
      px = '0;
      py = '0;
    end
    new_col[0] = lb2[px];
    new_col[1] = lb1[px];
    new_col[2] = pix_in;
    complete   = process && (px >= XW'(2)) && (py >= YW'(2));
  end

  // NOTE: line buffers and window hold pure data that is never emitted before being rewritten, so they carry no reset.
  always_ff @(posedge clk) begin
    if (process) begin
      lb2[px] <= lb1[px];
      lb1[px] <= pix_in;
      for (int r = 0; r < cellN; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= new_col[r];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= WAIT_SOF;
      x          <= '0;
      y          <= '0;
      cell_valid <= 1'b0;
      cell_last  <= 1'b0;
      cell_out   <= '0;
      cell_x     <= '0;
      cell_y     <= '0;
      sof_err    <= 1'b0;
    end else begin
      sof_err <= restart && (state == ACTIVE);

      if (process) begin
        state <= ACTIVE;
        y     <= py;
        if (px == XW'(IMG_W - 1)) begin
          x <= '0;
          if (py == YW'(IMG_H - 1)) begin
            y     <= '0;
            state <= DONE;
          end else begin
            y <= py + YW'(1);
          end
        end else begin
          x <= px + XW'(1);
        end
      end else if ((state == DONE) && emit) begin
        state <= WAIT_SOF;
      end

      // A new cell may load in the same cycle the previous one leaves
      if (complete) begin
        for (int r = 0; r < cellN; r++) begin
          cell_out.pixelMatrix[r][0] <= win[r][0];
          cell_out.pixelMatrix[r][1] <= win[r][1];
          cell_out.pixelMatrix[r][2] <= new_col[r];
        end
        cell_x     <= px - XW'(2);
        cell_y     <= py - YW'(2);
        cell_last  <= (px == XW'(IMG_W - 1)) && (py == YW'(IMG_H - 1));
        cell_valid <= 1'b1;
      end else if (emit) begin
        cell_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_image_cell_builder.sv
// Directed and randomised bench for image_cell_builder on a 5x4 frame; expected cells are
// computed from the pixel formula and queued on pixel acceptance, then matched on emission.
module tb_image_cell_builder;
  import CellProcessingPkg::*;

  localparam int W = 5;
  localparam int H = 4;

  logic        clk, reset, pix_sof, pix_valid, pix_ready;
  logic        cell_last, cell_valid, cell_ready, sof_err;
  pixel_t      pix_in;
  cell_t       cell_out;
  logic [2:0]  cell_x;
  logic [1:0]  cell_y;

  typedef struct {
    cell_t      c;
    logic [2:0] x;
    logic [1:0] y;
    logic       last;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   e_mon;
  int     checks = 0;
  int     errors = 0;
  int     n_cells = 0;
  int     sof_pulses = 0;
  int     base, sof_base;
  bit     rand_ready = 0;
  bit     rand_gap = 0;
  pixel_t center10;

  image_cell_builder #(.IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .reset     (reset),
    .pix_in    (pix_in),
    .pix_sof   (pix_sof),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .cell_out  (cell_out),
    .cell_x    (cell_x),
    .cell_y    (cell_y),
    .cell_last (cell_last),
    .cell_valid(cell_valid),
    .cell_ready(cell_ready),
    .sof_err   (sof_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic pixel_t pix(input int f, input int x, input int y);
    return {8'(y + 16 * f), 8'(x), 8'(16 * y + x)};
  endfunction

  function automatic cell_t exp_cell(input int f, input int cx, input int cy);
    cell_t c;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++)
        c.pixelMatrix[r][k] = pix(f, cx + k, cy + r);
    return c;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expd);
    checks++;
    assert (obs === expd)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
    end
  endtask

  // Presents one pixel starting at posedge+1, returns at posedge+1 after it was accepted.
  task automatic send_pix(input int f, input int x, input int y, input bit sof, input bit model);
    int   n;
    exp_t e;
    if (rand_gap) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    pix_in    = pix(f, x, y);
    pix_sof   = sof;
    pix_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!pix_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!pix_ready) check("pix_accept_timeout", pix_ready, 1);
    if (model && x >= 2 && y >= 2) begin
      e.c    = exp_cell(f, x - 2, y - 2);
      e.x    = 3'(x - 2);
      e.y    = 2'(y - 2);
      e.last = (x == W - 1) && (y == H - 1);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic send_frame(input int f, input int npix, input int stall_k);
    for (int k = 0; k < npix; k++) begin
      if (k == stall_k) cell_ready = 1'b0;
      send_pix(f, k % W, k / W, k == 0, 1'b1);
      if (k == stall_k) begin
        pix_in    = pix(f, (k + 1) % W, (k + 1) / W);
        pix_valid = 1'b1;
        repeat (5) begin
          @(negedge clk);
          check("stall_valid", cell_valid, 1);
          check("stall_pix_ready", pix_ready, 0);
          check("stall_cell", cell_out, exp_cell(f, k % W - 2, k / W - 2));
          check("stall_xy", {cell_x, cell_y}, {3'(k % W - 2), 2'(k / W - 2)});
          @(posedge clk); #1;
        end
        pix_valid  = 1'b0;
        cell_ready = 1'b1;
      end
    end
  endtask

  task automatic drain(input string tag, input int b, input int ncells);
    int n = 0;
    while ((exp_q.size() != 0 || cell_valid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_cell_count"}, n_cells - b, ncells);
    check({tag, "_pix_ready"}, pix_ready, 1);
  endtask

  // Output monitor: every emitted cell must match the oldest queued expectation
  initial forever begin
    @(negedge clk);
    if (sof_err) sof_pulses++;
    if (cell_valid && cell_ready) begin
      n_cells++;
      check("cell_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e_mon = exp_q.pop_front();
        check("cell_data", cell_out, e_mon.c);
        check("cell_x", cell_x, e_mon.x);
        check("cell_y", cell_y, e_mon.y);
        check("cell_last", cell_last, e_mon.last);
      end
      if (cell_x == 3'd1 && cell_y == 2'd0) center10 = cell_out.pixelMatrix[1][1];
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_ready) cell_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_in = '0; cell_ready = 1'b1;
    #1 reset = 1'b1;
    #11;
    check("rst_cell_valid", cell_valid, 0);
    check("rst_cell_last", cell_last, 0);
    check("rst_cell_out", cell_out, 0);
    check("rst_cell_xy", {cell_x, cell_y}, 0);
    check("rst_sof_err", sof_err, 0);
    check("rst_pix_ready", pix_ready, 1);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    // Free-running frame
    base = n_cells;
    send_frame(0, W * H, -1);
    drain("free", base, 6);
    check("center_1_0", center10, 24'h010212);

    // Back-pressure on cell (0,0)
    base = n_cells;
    send_frame(0, W * H, 12);
    drain("stall", base, 6);

    // Junk before SOF is dropped
    base = n_cells;
    for (int j = 0; j < 3; j++) send_pix(7, j, 1, 1'b0, 1'b0);
    send_frame(0, W * H, -1);
    drain("junk", base, 6);

    // SOF mid-frame restarts the frame
    base = n_cells;
    sof_base = sof_pulses;
    send_frame(1, 12, -1);
    send_frame(2, W * H, -1);
    drain("midsof", base, 6);
    check("midsof_sof_err", sof_pulses - sof_base, 1);

    // Async reset while a cell is waiting
    cell_ready = 1'b0;
    send_frame(0, 13, -1);
    check("pre_rst_valid", cell_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", cell_valid, 0);
    check("async_rst_out", cell_out, 0);
    check("async_rst_xy_last", {cell_x, cell_y, cell_last}, 0);
    exp_q.delete();
    cell_ready = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    #1 check("post_rst_pix_ready", pix_ready, 1);
    @(posedge clk); #1;
    base = n_cells;
    send_frame(3, W * H, -1);
    drain("after_rst", base, 6);

    // Random valid/ready over three frames
    base = n_cells;
    rand_gap   = 1'b1;
    rand_ready = 1'b1;
    send_frame(4, W * H, -1);
    send_frame(5, W * H, -1);
    send_frame(6, W * H, -1);
    rand_ready = 1'b0;
    rand_gap   = 1'b0;
    @(posedge clk); #1;
    cell_ready = 1'b1;
    drain("random", base, 18);

    check("sof_err_total", sof_pulses, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
